// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: pixel strobe divider, h/v counters, registered syncs, run/drain control.
// Optional completed-frame counter is built only when VGA_FRAME_CNT_EN is defined.
module vga_scan_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        pix_ce,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_ce_q, pix_ce_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic             last_pix;

    always_comb begin
        last_pix = pix_ce_q && (hcount_q == H_LAST) && (vcount_q == V_LAST);

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_DRAIN;
            S_DRAIN: begin
                if (en)            state_d = S_RUN;
                else if (last_pix) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_ce_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end

        // Divider restarts from zero on entry so the first pixel always lasts a full CLK_DIV clocks.
        if (state_d == S_IDLE || state_q == S_IDLE) div_d = '0;
        else if (div_q == DIV_LAST)                 div_d = '0;
        else                                        div_d = div_q + 1'b1;

        pix_ce_d      = (state_d != S_IDLE) && (div_d == DIV_LAST);
        hsync_d       = !((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST));
        vsync_d       = !((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST));
        video_on_d    = (state_d != S_IDLE) && (hcount_d < H_ACT) && (vcount_d < V_ACT);
        frame_start_d = ((state_q == S_IDLE) && (state_d == S_RUN)) ||
                        (last_pix && (state_d != S_IDLE));
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            pix_ce_q      <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            pix_ce_q      <= pix_ce_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (last_pix) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign pix_ce      = pix_ce_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: default-timing instance for the first line, a shrunken
// raster (24x18) for whole-frame behaviour, and a CLK_DIV=4 instance for strobe spacing.
module tb_vga_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small raster: H 16/2/4/2 (total 24, hsync 18..21), V 12/2/2/2 (total 18, vsync 14..15).
`ifdef VGA_FRAME_CNT_EN
    localparam int FC_ON = 1;
`else
    localparam int FC_ON = 0;
`endif

    logic        rst_n_a, en_a, pix_ce_a, hsync_a, vsync_a, video_on_a, frame_start_a, busy_a;
    logic [9:0]  hcount_a, vcount_a;
    logic [15:0] frame_cnt_a;
    logic        rst_n_b, en_b, pix_ce_b, hsync_b, vsync_b, video_on_b, frame_start_b, busy_b;
    logic [9:0]  hcount_b, vcount_b;
    logic [15:0] frame_cnt_b;
    logic        rst_n_c, en_c, pix_ce_c, hsync_c, vsync_c, video_on_c, frame_start_c, busy_c;
    logic [9:0]  hcount_c, vcount_c;
    logic [15:0] frame_cnt_c;

    vga_scan_ctrl u_a (
        .clk(clk), .rst_n(rst_n_a), .en(en_a), .pix_ce(pix_ce_a),
        .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
        .video_on(video_on_a), .frame_start(frame_start_a), .busy(busy_a), .frame_cnt(frame_cnt_a)
    );

    vga_scan_ctrl #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b), .pix_ce(pix_ce_b),
        .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
        .video_on(video_on_b), .frame_start(frame_start_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
    );

    vga_scan_ctrl #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_c (
        .clk(clk), .rst_n(rst_n_c), .en(en_c), .pix_ce(pix_ce_c),
        .hcount(hcount_c), .vcount(vcount_c), .hsync(hsync_c), .vsync(vsync_c),
        .video_on(video_on_c), .frame_start(frame_start_c), .busy(busy_c), .frame_cnt(frame_cnt_c)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, nstrobe, hs_low, hs_first, hs_last, vs_low, vs_min, vs_max, vid, fs, nb, t;
        int last_h, last_v, prev_h, prev_v, eh, ev;
        logic prev_ce;

        rst_n_a = 1'b0; en_a = 1'b0;
        rst_n_b = 1'b0; en_b = 1'b0;
        rst_n_c = 1'b0; en_c = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- default timing: reset, entry, first line ----------------
        chk("a_rst_flags", 32'({pix_ce_a, hsync_a, vsync_a, video_on_a, frame_start_a, busy_a}), 32'b011000);
        chk("a_rst_pos", 32'({hcount_a, vcount_a}), 0);
        chk("a_rst_frame_cnt", 32'(frame_cnt_a), 0);
        rst_n_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_idle_flags", 32'({pix_ce_a, hsync_a, vsync_a, video_on_a, frame_start_a, busy_a}), 32'b011000);
        en_a = 1'b1;
        @(negedge clk);
        chk("a_entry_flags", 32'({pix_ce_a, video_on_a, frame_start_a, busy_a}), 32'b0111);
        chk("a_entry_pos", 32'({hcount_a, vcount_a}), 0);

        bad = 0; nstrobe = 0; hs_low = 0; hs_first = 1023; hs_last = 0; vid = 0; fs = 0;
        for (int c = 0; c < 1600; c++) begin
            if (c > 0) @(negedge clk);
            if (hcount_a != 10'(c / 2) || vcount_a != 10'd0 || pix_ce_a != (c % 2 == 1)) bad++;
            if (frame_start_a) fs++;
            if (pix_ce_a) begin
                nstrobe++;
                if (video_on_a) vid++;
                if (!hsync_a) begin
                    hs_low++;
                    if (32'(hcount_a) < hs_first) hs_first = 32'(hcount_a);
                    if (32'(hcount_a) > hs_last)  hs_last  = 32'(hcount_a);
                end
            end
        end
        @(negedge clk);
        chk("a_line_seq_errs", bad, 0);
        chk("a_pix_ce_count", nstrobe, 800);
        chk("a_hsync_low_px", hs_low, 96);
        chk("a_hsync_first", hs_first, 656);
        chk("a_hsync_last", hs_last, 751);
        chk("a_video_line0", vid, 640);
        chk("a_frame_start_count", fs, 1);
        chk("a_line_wrap_pos", 32'({hcount_a, vcount_a}), 32'({10'd0, 10'd1}));

        // ---------------- CLK_DIV=4 strobe spacing ----------------
        rst_n_c = 1'b1;
        @(negedge clk);
        en_c = 1'b1;
        @(negedge clk);
        chk("c_entry_frame_start", 32'(frame_start_c), 1);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (pix_ce_c != (c % 4 == 3)) bad++;
        end
        @(negedge clk);
        chk("c_pix_ce_period_errs", bad, 0);
        chk("c_hcount_after_40", 32'(hcount_c), 10);

        // ---------------- small raster: full frame ----------------
        rst_n_b = 1'b1;
        @(negedge clk);
        en_b = 1'b1;
        @(negedge clk);
        chk("b_entry_frame_start", 32'(frame_start_b), 1);
        nstrobe = 0; vid = 0; hs_low = 0; vs_low = 0; vs_min = 1023; vs_max = 0; nb = 0; fs = 0;
        for (int c = 0; c < 864; c++) begin
            if (c > 0) @(negedge clk);
            if (!busy_b) nb++;
            if (frame_start_b) fs++;
            if (pix_ce_b) begin
                nstrobe++;
                if (video_on_b) vid++;
                if (!hsync_b) hs_low++;
                if (!vsync_b) begin
                    vs_low++;
                    if (32'(vcount_b) < vs_min) vs_min = 32'(vcount_b);
                    if (32'(vcount_b) > vs_max) vs_max = 32'(vcount_b);
                end
            end
        end
        @(negedge clk);
        chk("b_frame_strobes", nstrobe, 432);
        chk("b_video_strobes", vid, 192);
        chk("b_hsync_low_strobes", hs_low, 72);
        chk("b_vsync_low_strobes", vs_low, 48);
        chk("b_vsync_first_line", vs_min, 14);
        chk("b_vsync_last_line", vs_max, 15);
        chk("b_frame_busy_drops", nb, 0);
        chk("b_frame_start_count", fs, 1);
        chk("b_frame2_start", 32'({frame_start_b, hcount_b, vcount_b}), 32'({1'b1, 20'd0}));
        chk("b_frame_cnt_1", 32'(frame_cnt_b), 1 * FC_ON);
        repeat (1728) @(negedge clk);
        chk("b_frame4_start", 32'({frame_start_b, hcount_b, vcount_b}), 32'({1'b1, 20'd0}));
        chk("b_frame_cnt_3", 32'(frame_cnt_b), 3 * FC_ON);

        // ---------------- small raster: stop mid-frame drains to end ----------------
        t = 0;
        while (!(hcount_b == 10'd10 && vcount_b == 10'd5) && t < 1000) begin
            @(negedge clk); t++;
        end
        chk("b_reach_10_5", 32'(t < 1000), 1);
        en_b = 1'b0;
        t = 0; fs = 0; last_h = 0; last_v = 0;
        while (busy_b && t < 1000) begin
            last_h = 32'(hcount_b); last_v = 32'(vcount_b);
            if (frame_start_b) fs++;
            @(negedge clk); t++;
        end
        chk("b_drain_bounded", 32'(t < 1000), 1);
        chk("b_drain_last_h", last_h, 23);
        chk("b_drain_last_v", last_v, 17);
        chk("b_drain_no_new_frame", fs, 0);
        chk("b_idle_flags", 32'({pix_ce_b, hsync_b, vsync_b, video_on_b, frame_start_b, busy_b}), 32'b011000);
        chk("b_idle_pos", 32'({hcount_b, vcount_b}), 0);
        chk("b_drain_frame_cnt", 32'(frame_cnt_b), 4 * FC_ON);
        repeat (4) @(negedge clk);
        chk("b_idle_hold", 32'({busy_b, frame_start_b, pix_ce_b, hcount_b}), 0);

        // ---------------- small raster: short en dropout keeps scanning ----------------
        en_b = 1'b1;
        @(negedge clk);
        chk("b_restart_frame_start", 32'(frame_start_b), 1);
        t = 0;
        while (!(hcount_b == 10'd8 && vcount_b == 10'd3) && t < 1000) begin
            @(negedge clk); t++;
        end
        chk("b_reach_8_3", 32'(t < 1000), 1);
        bad = 0; nb = 0;
        prev_h = 32'(hcount_b); prev_v = 32'(vcount_b); prev_ce = pix_ce_b;
        for (int c = 0; c < 300; c++) begin
            if (c == 2) en_b = 1'b0;
            if (c == 5) en_b = 1'b1;
            @(negedge clk);
            eh = prev_h; ev = prev_v;
            if (prev_ce) begin
                if (prev_h == 23) begin
                    eh = 0;
                    ev = (prev_v == 17) ? 0 : prev_v + 1;
                end else begin
                    eh = prev_h + 1;
                end
            end
            if (32'(hcount_b) != eh || 32'(vcount_b) != ev) bad++;
            if (!busy_b) nb++;
            prev_h = 32'(hcount_b); prev_v = 32'(vcount_b); prev_ce = pix_ce_b;
        end
        chk("b_pulse_counter_jumps", bad, 0);
        chk("b_pulse_busy_drops", nb, 0);
        t = 0;
        while (!frame_start_b && t < 1000) begin
            @(negedge clk); t++;
        end
        chk("b_pulse_next_frame_seen", 32'(t < 1000), 1);
        chk("b_pulse_next_frame_state", 32'({busy_b, hcount_b, vcount_b}), 32'({1'b1, 20'd0}));

        // ---------------- small raster: asynchronous reset mid-frame ----------------
        t = 0;
        while (!(hcount_b == 10'd12 && vcount_b == 10'd9) && t < 1000) begin
            @(negedge clk); t++;
        end
        chk("b_reach_12_9", 32'(t < 1000), 1);
        rst_n_b = 1'b0;
        en_b    = 1'b0;
        #1;
        chk("b_async_rst_flags", 32'({pix_ce_b, hsync_b, vsync_b, video_on_b, frame_start_b, busy_b}), 32'b011000);
        chk("b_async_rst_pos", 32'({hcount_b, vcount_b}), 0);
        chk("b_async_rst_frame_cnt", 32'(frame_cnt_b), 0);
        @(negedge clk);
        rst_n_b = 1'b1;
        fs = 0; nb = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (frame_start_b) fs++;
            if (busy_b) nb++;
        end
        chk("b_post_rst_no_frame", fs, 0);
        chk("b_post_rst_not_busy", nb, 0);
        en_b = 1'b1;
        @(negedge clk);
        chk("b_post_rst_restart", 32'({frame_start_b, busy_b, hcount_b, vcount_b}), 32'({2'b11, 20'd0}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2: system clocks per pixel (2..16).
REQ-002 The block SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, giving pixel counts per horizontal region.
REQ-003 The block SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, giving line counts per vertical region.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; the only clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: request scanning.
REQ-007 The block SHALL have port pix_ce, output, 1 bit: one-clk pixel strobe.
REQ-008 The block SHALL have ports hcount and vcount, outputs, 10 bits each: current pixel column and line.
REQ-009 The block SHALL have ports hsync and vsync, outputs, 1 bit each, active-low.
REQ-010 The block SHALL have ports video_on, frame_start and busy, outputs, 1 bit each.
REQ-011 The block SHALL have port frame_cnt, output, 16 bits: completed-frame count.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, RUN and DRAIN; IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->RUN when en=1; DRAIN->IDLE on the last pixel of the frame (hcount=H_TOTAL-1, vcount=V_TOTAL-1, pix_ce=1).
REQ-013 In RUN/DRAIN a divider SHALL count 0..CLK_DIV-1, and pix_ce SHALL be 1 for exactly the clk in which the divider equals CLK_DIV-1; in IDLE the divider SHALL hold 0 and pix_ce SHALL be 0.
REQ-014 hcount SHALL advance only when pix_ce=1 and SHALL wrap H_TOTAL-1->0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
REQ-015 vcount SHALL advance only when hcount wraps and SHALL wrap V_TOTAL-1->0, where V_TOTAL = 525.
REQ-016 hsync SHALL be 0 iff hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
REQ-017 vsync SHALL be 0 iff vcount is in 490..491.
REQ-018 video_on SHALL be 1 iff hcount<H_ACTIVE and vcount<V_ACTIVE and the state is not IDLE.
REQ-019 hsync, vsync and video_on SHALL be registered and aligned to the same clk edge as hcount/vcount, with zero added latency.
REQ-020 frame_start SHALL pulse for exactly one clk when the counters move to (0,0) while the state is RUN or DRAIN, including the first IDLE->RUN entry.
REQ-021 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-022 Leaving DRAIN to IDLE SHALL leave hcount=0, vcount=0, hsync=1 and vsync=1, and no partial frame SHALL ever be emitted on stop.
REQ-023 When en toggles 1->0->1 within one frame, scanning SHALL continue without any counter discontinuity.

Reset
REQ-024 While rst_n=0 the block SHALL be in IDLE with divider=0, hcount=0, vcount=0, pix_ce=0, hsync=1, vsync=1, video_on=0, frame_start=0, busy=0 and frame_cnt=0, all asynchronously.
REQ-025 Reset asserted mid-frame SHALL abort immediately, and after release the block SHALL restart from (0,0) only when en=1.

Configuration
REQ-026 With macro VGA_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 modulo 2^16 on each DRAIN/RUN last-pixel event.
REQ-027 Without VGA_FRAME_CNT_EN, frame_cnt SHALL be the constant 0 and no counter logic SHALL be generated.

Verification
REQ-028 The bench SHALL check: reset release, en=1 -> frame_start at the first clk after the IDLE->RUN transition, pix_ce every 2nd clk, hcount 0..799 then vcount=1.
REQ-029 The bench SHALL check one full frame with defaults: hsync low for 96 pixels at 656, vsync low for lines 490-491, and video_on high for 640x480=307200 pixel strobes.
REQ-030 The bench SHALL check en=0 at (100,200): busy stays 1 until (799,524), then IDLE with counters (0,0) and hsync/vsync=1.
REQ-031 The bench SHALL check en pulse 1->0->1 at (300,50): no counter jump, state returns to RUN, and busy stays 1 throughout.
REQ-032 The bench SHALL check rst_n=0 at (400,300): all outputs at reset values within the same clk, and no frame_start until en=1.
REQ-033 The bench SHALL check that with VGA_FRAME_CNT_EN, 3 full frames give frame_cnt=3, and without it frame_cnt stays 0; it SHALL also check that with CLK_DIV=4, pix_ce has period 4 clks.
